// File: rtl/ram_bist_master_if.sv
// RAM access bus between the BIST master and a single-port RAM.
// The master drives enable/write/address/data; the RAM returns read data one cycle later.
interface ram_bist_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  out_ram_en;
    logic                  out_ram_we;
    logic [ADDR_WIDTH-1:0] out_ram_addr;
    logic [DATA_WIDTH-1:0] out_ram_wdata;
    logic [DATA_WIDTH-1:0] in_ram_rdata;

    modport master (
        output out_ram_en,
        output out_ram_we,
        output out_ram_addr,
        output out_ram_wdata,
        input  in_ram_rdata
    );

    modport slave (
        input  out_ram_en,
        input  out_ram_we,
        input  out_ram_addr,
        input  out_ram_wdata,
        output in_ram_rdata
    );
endinterface

// File: rtl/ram_bist_master.sv
// RAM BIST initiator: write pattern, read back, compare, report pass/fail and first error.
// Optional second inverted-pattern pass when RAM_BIST_INVERT_PASS_EN is defined.
module ram_bist_master #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN_KEY = 8'hA5
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_start,
    output logic                  out_busy,
    output logic                  out_done,
    output logic                  out_pass,
    output logic [15:0]           out_err_cnt,
    output logic [ADDR_WIDTH-1:0] out_first_err_addr,
    ram_bist_master_if.master     ram
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
`ifdef RAM_BIST_INVERT_PASS_EN
        ,
        S_INV_WRITE,
        S_INV_READ,
        S_INV_DRAIN
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  cmp_valid_q, cmp_valid_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic                  exp_inv_q, exp_inv_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
    logic                  pass_q, pass_d;

    logic                  start_acc;
    logic                  mismatch;
    logic                  in_write, in_read, wr_inv, final_drain;
    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic inv);
        logic [DATA_WIDTH-1:0] v;
        v = DATA_WIDTH'(a) ^ PATTERN_KEY;
        return inv ? ~v : v;
    endfunction

    // State register and datapath flops
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmp_valid_q <= 1'b0;
            exp_addr_q  <= '0;
            exp_inv_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmp_valid_q <= cmp_valid_d;
            exp_addr_q  <= exp_addr_d;
            exp_inv_q   <= exp_inv_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (in_start) state_d = S_WRITE;
            S_WRITE:     if (cnt_q == LAST_ADDR) state_d = S_READ;
            S_READ:      if (cnt_q == LAST_ADDR) state_d = S_DRAIN;
`ifdef RAM_BIST_INVERT_PASS_EN
            S_DRAIN:     state_d = S_INV_WRITE;
            S_INV_WRITE: if (cnt_q == LAST_ADDR) state_d = S_INV_READ;
            S_INV_READ:  if (cnt_q == LAST_ADDR) state_d = S_INV_DRAIN;
            S_INV_DRAIN: state_d = S_DONE;
`else
            S_DRAIN:     state_d = S_DONE;
`endif
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Phase decode and RAM-side outputs
    always_comb begin
`ifdef RAM_BIST_INVERT_PASS_EN
        in_write    = (state_q == S_WRITE) || (state_q == S_INV_WRITE);
        in_read     = (state_q == S_READ)  || (state_q == S_INV_READ);
        wr_inv      = (state_q == S_INV_WRITE);
        final_drain = (state_q == S_INV_DRAIN);
`else
        in_write    = (state_q == S_WRITE);
        in_read     = (state_q == S_READ);
        wr_inv      = 1'b0;
        final_drain = (state_q == S_DRAIN);
`endif
        ram_en    = in_write || in_read;
        ram_we    = in_write;
        ram_addr  = ram_en ? cnt_q : '0;
        ram_wdata = in_write ? pattern(cnt_q, wr_inv) : '0;
        out_busy  = (state_q != S_IDLE) && (state_q != S_DONE);
        out_done  = (state_q == S_DONE);
    end

    // Counter, compare pipeline and result accumulation
    always_comb begin
        start_acc   = (state_q == S_IDLE) && in_start;
        mismatch    = cmp_valid_q && (ram.in_ram_rdata != pattern(exp_addr_q, exp_inv_q));

        cnt_d       = ram_en ? cnt_q + 1'b1 : cnt_q;
        cmp_valid_d = in_read;
        exp_addr_d  = cnt_q;
`ifdef RAM_BIST_INVERT_PASS_EN
        exp_inv_d   = (state_q == S_INV_READ);
`else
        exp_inv_d   = 1'b0;
`endif
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        if (start_acc) begin
            cnt_d       = '0;
            err_cnt_d   = '0;
            first_err_d = '0;
            pass_d      = 1'b0;
        end else begin
            if (mismatch) begin
                // The count never returns to zero, so zero means no mismatch yet this run
                if (err_cnt_q == 16'd0) first_err_d = exp_addr_q;
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end
            if (final_drain) pass_d = (err_cnt_d == 16'd0);
        end
    end

    assign out_pass           = pass_q;
    assign out_err_cnt        = err_cnt_q;
    assign out_first_err_addr = first_err_q;

    assign ram.out_ram_en    = ram_en;
    assign ram.out_ram_we    = ram_we;
    assign ram.out_ram_addr  = ram_addr;
    assign ram.out_ram_wdata = ram_wdata;
endmodule
